sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
- Next-generation synchronous FIFO: parametrised width, any depth ≥ 2 (not only powers of two), and selectable read mode (registered or first-word-fall-through).
- Inputs are level-sensitive enables: one accepted operation per cycle per side. No edge detection.
- Adds an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses.
- Used as the generic buffering block between single-clock producer/consumer datapaths.

Parameters:
- WIDTH, 16: data width in bits, ≥ 1.
- DEPTH, 4: number of entries, ≥ 2; non-power-of-two allowed.
- FWFT, 0: read mode. 0 = registered read (1-cycle latency); 1 = first-word-fall-through.
- AF_THRESH, DEPTH-1: almost_full_o asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty_o asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk_i, input, 1: clock; all logic on the rising edge.
- rst_i, input, 1: reset. Synchronous, active-high.
- wr_en_i, input, 1: write request (level).
- wr_data_i, input, WIDTH: write data.
- rd_en_i, input, 1: read/pop request (level).
- rd_data_o, output, WIDTH: read data.
- full_o, output, 1: count == DEPTH.
- empty_o, output, 1: count == 0.
- almost_full_o, output, 1: count ≥ AF_THRESH.
- almost_empty_o, output, 1: count ≤ AE_THRESH.
- count_o, output, $clog2(DEPTH+1): current occupancy.
- overflow_o, output, 1: 1-cycle pulse when a write is rejected.
- underflow_o, output, 1: 1-cycle pulse when a read is rejected.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - Pointers and count go to 0; rd_data_o=0; overflow_o=underflow_o=0.
  - empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=(AF_THRESH==0 → never legal, so 0).
  - Storage array is not reset.
  - Reset overrides any same-cycle wr_en_i/rd_en_i. Reset mid-operation discards all contents.
- Acceptance:
  - wr_acc = wr_en_i & !full_o.
  - rd_acc = rd_en_i & !empty_o.
  - Both are evaluated on the registered flags at the start of the cycle.
- Write: on wr_acc, mem[wptr] ← wr_data_i and wptr advances.
- Pointer wrap: each pointer wraps from DEPTH-1 to 0 explicitly (no reliance on binary overflow).
- Count update: +1 on wr_acc only; −1 on rd_acc only; unchanged when both or neither occur.
  - Full with simultaneous rd_en_i & wr_en_i: the read is accepted, the write is rejected (overflow_o pulses), and the count becomes DEPTH-1.
  - Empty with both enables: the write is accepted, the read is rejected (underflow_o pulses).
- Flags: all flags and count_o are registered, derived from next-state count, and valid the cycle after the causing edge.
- Error pulses:
  - overflow_o = registered (wr_en_i & full_o).
  - underflow_o = registered (rd_en_i & empty_o).
  - Both are high for exactly one cycle per offending request cycle.
- FWFT=0 (registered read):
  - On rd_acc, rd_data_o ← mem[rptr] at that edge, so data is visible the cycle after rd_en_i.
  - rd_data_o holds its value otherwise.
- FWFT=1 (first-word-fall-through):
  - rd_data_o = mem[rptr] combinationally while empty_o=0.
  - rd_en_i acts as acknowledge/pop.
  - A write into an empty FIFO appears on rd_data_o the cycle after the write edge, together with empty_o deasserting.
  - rd_data_o is unspecified while empty_o=1.
- Widths: count_o is $clog2(DEPTH+1) bits; pointers are $clog2(DEPTH) bits. Arithmetic never exceeds DEPTH.
- Illegal parameters (DEPTH<2, thresholds out of range) are rejected by elaboration-time assertions.

Decomposition:
- Shared package sync_fifo_pkg holds:
  - fifo_mode_e enum (FIFO_STD=0, FIFO_FWFT=1).
  - Function ptr_w(depth) returning max(1,$clog2(depth)).
  - Function cnt_w(depth) returning $clog2(depth+1).
- One sub-module, fifo_wrap_ptr: parametrised pointer that increments on en_i and wraps at DEPTH-1. Instantiated twice, for wptr and rptr.

Test Plan (WIDTH=16, DEPTH=4 unless stated):
- Fill/drain, FWFT=0:
  - Write 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles → full_o=1, count_o=4, almost_full_o=1 from count 3.
  - Read 4 times → rd_data_o = 0x1111..0x4444, each one cycle after its rd_en_i; then empty_o=1.
- Overflow/underflow:
  - Write a 5th word 0xDEAD while full → overflow_o pulses 1 cycle, count_o stays 4, 0xDEAD never read.
  - Read when empty → underflow_o pulses 1 cycle, rd_data_o holds its last value.
- Simultaneous ops:
  - At count=2, assert wr_en_i and rd_en_i together for 3 cycles → count_o stays 2; order preserved.
  - At full, assert both → count_o=3, overflow_o=1.
- Wrap-around with non-power-of-two depth (DEPTH=5):
  - Stream 12 words with interleaved reads → output matches the 12-word sequence exactly; no loss or duplication across pointer wrap.
- FWFT=1:
  - Write 0xA5A5 into an empty FIFO → next cycle empty_o=0 and rd_data_o=0xA5A5 with no rd_en_i.
  - Pop → empty_o=1 the following cycle.
- Reset mid-operation:
  - At count=3, assert rst_i for 1 cycle with wr_en_i=1 → count_o=0, empty_o=1, rd_data_o=0, no write accepted.
  - Subsequent write/read round-trips 0x0F0F correctly.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared mode enum and width helpers for sync_fifo_flex.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int ptr_w(input int depth);
        return ($clog2(depth) > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: storage index that advances on en_i and wraps from DEPTH-1 to 0.
module fifo_wrap_ptr
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    output logic [ptr_w(DEPTH)-1:0] ptr_o
);

    localparam int PW = ptr_w(DEPTH);

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_o <= '0;
        else if (en_i) ptr_o <= (ptr_o == PW'(DEPTH - 1)) ? '0 : ptr_o + PW'(1);
    end

endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO, any depth >= 2, registered or FWFT read,
// with occupancy count, almost flags and overflow/underflow pulses.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_en_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    input  logic                    rd_en_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o,
    output logic [cnt_w(DEPTH)-1:0] count_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_flex: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flex: DEPTH must be >= 2");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
        $error("sync_fifo_flex: FWFT must be 0 or 1");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flex: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flex: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [CW-1:0]    cnt_nxt;

    // Acceptance uses the registered flags, so full+both pops only and empty+both pushes only.
    assign wr_acc  = wr_en_i & ~full_o;
    assign rd_acc  = rd_en_i & ~empty_o;
    assign cnt_nxt = count_o + CW'(wr_acc) - CW'(rd_acc);

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (wr_acc),
        .ptr_o (wptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (rd_acc),
        .ptr_o (rptr)
    );

    always_ff @(posedge clk_i) begin
        if (wr_acc && !rst_i) mem[wptr] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            count_o        <= cnt_nxt;
            full_o         <= cnt_nxt == CW'(DEPTH);
            empty_o        <= cnt_nxt == '0;
            almost_full_o  <= cnt_nxt >= CW'(AF_THRESH);
            almost_empty_o <= cnt_nxt <= CW'(AE_THRESH);
            overflow_o     <= wr_en_i & full_o;
            underflow_o    <= rd_en_i & empty_o;
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign rd_data_o = empty_o ? '0 : mem[rptr];
    end else begin : g_std
        always_ff @(posedge clk_i) begin
            if (rst_i) rd_data_o <= '0;
            else if (rd_acc) rd_data_o <= mem[rptr];
        end
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: drives a registered-read DEPTH=4 FIFO and an FWFT DEPTH=5 FIFO
// with shared stimulus and compares both against queue-based reference models.
module tb_sync_fifo_flex;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] wr_data = '0;

    logic [15:0] a_rd_data, b_rd_data;
    logic        a_full, a_empty, a_af, a_ae, a_ov, a_un;
    logic        b_full, b_empty, b_af, b_ae, b_ov, b_un;
    logic [2:0]  a_cnt, b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] a_last;
    bit          a_ov_m, a_un_m, b_ov_m, b_un_m;

    always #5 clk = ~clk;

    sync_fifo_flex #(.WIDTH(16), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_a (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .rd_en_i        (rd_en),
        .rd_data_o      (a_rd_data),
        .full_o         (a_full),
        .empty_o        (a_empty),
        .almost_full_o  (a_af),
        .almost_empty_o (a_ae),
        .count_o        (a_cnt),
        .overflow_o     (a_ov),
        .underflow_o    (a_un)
    );

    sync_fifo_flex #(.WIDTH(16), .DEPTH(5), .FWFT(1), .AF_THRESH(3), .AE_THRESH(2)) u_b (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .rd_en_i        (rd_en),
        .rd_data_o      (b_rd_data),
        .full_o         (b_full),
        .empty_o        (b_empty),
        .almost_full_o  (b_af),
        .almost_empty_o (b_ae),
        .count_o        (b_cnt),
        .overflow_o     (b_ov),
        .underflow_o    (b_un)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit w, input logic [15:0] d, input bit r, input bit rs);
        bit push, pop;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        rst     = rs;
        @(posedge clk);
        if (rs) begin
            qa.delete();
            qb.delete();
            a_last = '0;
            {a_ov_m, a_un_m, b_ov_m, b_un_m} = '0;
        end else begin
            a_ov_m = w && qa.size() == 4;
            a_un_m = r && qa.size() == 0;
            push   = w && qa.size() != 4;
            pop    = r && qa.size() != 0;
            if (pop) a_last = qa.pop_front();
            if (push) qa.push_back(d);
            b_ov_m = w && qb.size() == 5;
            b_un_m = r && qb.size() == 0;
            push   = w && qb.size() != 5;
            pop    = r && qb.size() != 0;
            if (pop) void'(qb.pop_front());
            if (push) qb.push_back(d);
        end
        #1;
        check("a_count", 32'(a_cnt), qa.size());
        check("a_full", 32'(a_full), 32'(qa.size() == 4));
        check("a_empty", 32'(a_empty), 32'(qa.size() == 0));
        check("a_almost_full", 32'(a_af), 32'(qa.size() >= 3));
        check("a_almost_empty", 32'(a_ae), 32'(qa.size() <= 1));
        check("a_overflow", 32'(a_ov), 32'(a_ov_m));
        check("a_underflow", 32'(a_un), 32'(a_un_m));
        check("a_rd_data", 32'(a_rd_data), 32'(a_last));
        check("b_count", 32'(b_cnt), qb.size());
        check("b_full", 32'(b_full), 32'(qb.size() == 5));
        check("b_empty", 32'(b_empty), 32'(qb.size() == 0));
        check("b_almost_full", 32'(b_af), 32'(qb.size() >= 3));
        check("b_almost_empty", 32'(b_ae), 32'(qb.size() <= 2));
        check("b_overflow", 32'(b_ov), 32'(b_ov_m));
        check("b_underflow", 32'(b_un), 32'(b_un_m));
        if (qb.size() != 0) check("b_rd_data", 32'(b_rd_data), 32'(qb[0]));
    endtask

    initial begin
        int wp, rp;
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        step(1, 16'h1111, 0, 0);
        step(1, 16'h2222, 0, 0);
        step(1, 16'h3333, 0, 0);
        step(1, 16'h4444, 0, 0);
        step(1, 16'hDEAD, 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(1, 16'h5555, 0, 0);
        step(1, 16'h6666, 0, 0);
        step(1, 16'h7777, 1, 0);
        step(1, 16'h8888, 1, 0);
        step(1, 16'h9999, 1, 0);
        step(1, 16'hAAAA, 0, 0);
        step(1, 16'hBBBB, 0, 0);
        step(1, 16'hCCCC, 1, 0);
        step(1, 16'hEEEE, 0, 1);
        step(1, 16'h0F0F, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        step(1, 16'hA5A5, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 16'h1000 + 16'(i), (i % 3) == 2, 0);
        for (int i = 0; i < 6; i++) step(0, '0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            wp = (i / 250) % 3 == 0 ? 70 : (i / 250) % 3 == 1 ? 30 : 50;
            rp = 100 - wp;
            step($urandom_range(0, 99) < wp, 16'($urandom), $urandom_range(0, 99) < rp,
                 $urandom_range(0, 299) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
